// File: rtl/titan_if_stage_pkg.sv
// Shared types and constants for the titan instruction-fetch stage:
// NOP encoding, fetch FSM states and the IF/ID slot layout.
package titan_if_stage_pkg;

  localparam logic [31:0] NOP            = 32'h0000_0013;
  localparam logic [31:0] RESET_ADDR_DEF = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_ABORT = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misaligned;
    logic        access_fault;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{pc: 32'h0000_0000, instr: NOP,
                                    misaligned: 1'b0, access_fault: 1'b0};

  function automatic ifid_t make_entry(input logic [31:0] pc, input logic [31:0] instr,
                                       input logic misaligned, input logic access_fault);
    ifid_t e;
    e.pc           = pc;
    e.instr        = instr;
    e.misaligned   = misaligned;
    e.access_fault = access_fault;
    return e;
  endfunction

endpackage

// File: rtl/titan_if_stage_if.sv
// Wishbone-style instruction port between the fetch stage (master) and memory (slave).
interface titan_if_stage_if;
  logic [31:0] addr;
  logic        cyc;
  logic        stb;
  logic [31:0] data;
  logic        ack;
  logic        err;

  modport master (output addr, cyc, stb, input data, ack, err);
  modport slave  (input addr, cyc, stb, output data, ack, err);
endinterface

// File: rtl/titan_if_stage_ifid.sv
// IF/ID pipeline register: reset > flush > stall > load, bubbles on reset and flush.
module titan_ifid_register
  import titan_if_stage_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  stall,
  input  logic  flush,
  input  ifid_t load_entry,
  output ifid_t entry
);

  ifid_t entry_r;

  // IF/ID slot update
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_r <= IFID_BUBBLE;
    end else if (flush) begin
      entry_r <= IFID_BUBBLE;
    end else if (stall) begin
      entry_r <= entry_r;
    end else begin
      entry_r <= load_entry;
    end
  end

  assign entry = entry_r;

endmodule

// File: rtl/titan_if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction port, applies
// redirects and feeds the IF/ID register.
module titan_if_stage
  import titan_if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_stall_i,
  input  logic              if_flush_i,
  input  logic              take_branch_i,
  input  logic [31:0]       pc_branch_address_i,
  input  logic              take_jump_i,
  input  logic [31:0]       pc_jump_address_i,
  input  logic              xcpt_take_i,
  input  logic [31:0]       pc_xcpt_address_i,
  titan_if_stage_if.master  iport,
  output logic [31:0]       id_pc_o,
  output logic [31:0]       id_instruction_o,
  output logic              id_inst_addr_misaligned_o,
  output logic              id_inst_access_fault_o
);

  fetch_state_e state_r, state_s;
  logic [31:0]  pc_r, pc_s;
  logic [31:0]  abort_addr_r, abort_addr_s;
  ifid_t        skid_r, skid_s;
  ifid_t        ld_entry_s, resp_entry_s, ifid_q_s;
  logic         redirect_s, kill_s, stb_s, done_s, misaligned_s;
  logic [31:0]  target_s, fetch_addr_s;

  assign misaligned_s = (pc_r[1:0] != 2'b00);
  // ABORT keeps presenting the abandoned address until the slave ends the cycle
  assign fetch_addr_s = (state_r == ST_ABORT) ? abort_addr_r : {pc_r[31:2], 2'b00};
  assign stb_s        = ((state_r == ST_RUN) && !misaligned_s) || (state_r == ST_ABORT);
  assign done_s       = stb_s && (iport.ack || iport.err);
  assign resp_entry_s = iport.err ? make_entry(pc_r, NOP, 1'b0, 1'b1)
                                  : make_entry(pc_r, iport.data, 1'b0, 1'b0);

  assign iport.addr = fetch_addr_s;
  assign iport.stb  = stb_s && !rst_i;
  assign iport.cyc  = stb_s && !rst_i;

  // redirect priority mux; only exceptions reach a faulted or stalled stage
  always_comb begin
    redirect_s = 1'b0;
    target_s   = pc_r;
    if (xcpt_take_i) begin
      redirect_s = 1'b1;
      target_s   = pc_xcpt_address_i;
    end else if ((state_r != ST_FAULT) && !if_stall_i && take_branch_i) begin
      redirect_s = 1'b1;
      target_s   = pc_branch_address_i;
    end else if ((state_r != ST_FAULT) && !if_stall_i && take_jump_i) begin
      redirect_s = 1'b1;
      target_s   = pc_jump_address_i;
    end else begin
      redirect_s = 1'b0;
    end
  end

  // fetch FSM next state, PC, skid buffer and IF/ID load value
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    abort_addr_s = abort_addr_r;
    skid_s       = skid_r;
    ld_entry_s   = IFID_BUBBLE;
    kill_s       = if_flush_i || redirect_s;
    case (state_r)
      ST_RUN: begin
        if (redirect_s) begin
          pc_s = target_s;
          if (stb_s && !done_s) begin
            state_s      = ST_ABORT;
            abort_addr_s = fetch_addr_s;
          end else begin
            state_s = ST_RUN;
          end
        end else if (misaligned_s) begin
          ld_entry_s = make_entry(pc_r, NOP, 1'b1, 1'b0);
          state_s    = if_stall_i ? ST_RUN : ST_FAULT;
        end else if (done_s) begin
          pc_s = pc_r + 32'd4;
          if (if_stall_i) begin
            skid_s  = resp_entry_s;
            state_s = ST_HOLD;
          end else begin
            ld_entry_s = resp_entry_s;
            state_s    = iport.err ? ST_FAULT : ST_RUN;
          end
        end else begin
          ld_entry_s = IFID_BUBBLE;
        end
      end
      ST_ABORT: begin
        if (redirect_s) begin
          pc_s = target_s;
        end else begin
          pc_s = pc_r;
        end
        state_s = done_s ? ST_RUN : ST_ABORT;
      end
      ST_HOLD: begin
        if (redirect_s) begin
          pc_s    = target_s;
          state_s = ST_RUN;
        end else if (!if_stall_i) begin
          ld_entry_s = skid_r;
          state_s    = skid_r.access_fault ? ST_FAULT : ST_RUN;
        end else begin
          state_s = ST_HOLD;
        end
      end
      ST_FAULT: begin
        if (redirect_s) begin
          pc_s    = target_s;
          state_s = ST_RUN;
        end else begin
          state_s = ST_FAULT;
        end
      end
      default: begin
        state_s = ST_RUN;
      end
    endcase
  end

  // fetch state, PC and skid registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= ST_RUN;
      pc_r         <= RESET_ADDR;
      abort_addr_r <= RESET_ADDR;
      skid_r       <= IFID_BUBBLE;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      abort_addr_r <= abort_addr_s;
      skid_r       <= skid_s;
    end
  end

  titan_ifid_register u_ifid (
    .clk        (clk_i),
    .rst        (rst_i),
    .stall      (if_stall_i),
    .flush      (kill_s),
    .load_entry (ld_entry_s),
    .entry      (ifid_q_s)
  );

  assign id_pc_o                   = ifid_q_s.pc;
  assign id_instruction_o          = ifid_q_s.instr;
  assign id_inst_addr_misaligned_o = ifid_q_s.misaligned;
  assign id_inst_access_fault_o    = ifid_q_s.access_fault;

endmodule
